aes_key_expand_seq: RTL and testbench
=====================================

// Module: aes_key_expand_seq
// PURPOSE
//  Iterative AES-128 key-expansion sequencer. Captures a 128-bit cipher key and produces one round key per clock.
//  Writes round keys 0..10 into the round-key register file via a single write port.
//  The register file's 16:1 read mux then serves keys to the cipher datapath.
//  Sits directly upstream of the register file in KeyExpansion.
// PARAMETERS
//  KEY_W       128  round-key width (fixed for AES-128; not to be overridden)
//  ADDR_W      4    register-file address width (16 slots; 0..10 used)
//  NUM_ROUNDS  10   last round-key index written (keys 0..NUM_ROUNDS)
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       asynchronous, active-high reset
//  start     in   1       request expansion of key_in; sampled only in IDLE
//  key_in    in   KEY_W   cipher key; [127:96]=w0 ... [31:0]=w3, byte 0 at MSB (FIPS-197 order)
//  busy      out  1       high while round keys are being written
//  done      out  1       one-cycle pulse after round key NUM_ROUNDS is written
//  wr_en     out  1       register-file write strobe
//  wr_addr   out  ADDR_W  register-file slot = round index
//  wr_data   out  KEY_W   round key for slot wr_addr
// BEHAVIOUR
//  - All outputs registered. Reset values: busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0.
//    Reset also clears the internal key register and loads rcon=8'h01.
//  - FSM states: IDLE -> EXPAND -> FIN -> IDLE.
//    IDLE: when start=1 at edge T, latch key_in, set round=0 and rcon=01, and enter EXPAND.
//    EXPAND, cycle T+1: wr_en=1, wr_addr=0, wr_data=key_in (round key 0).
//    EXPAND, cycles T+2..T+11: each cycle writes round key i (i=1..10) to addr i.
//      Round key i is computed combinationally from round key i-1.
//    FIN: at T+12, wr_en=0, busy=0, done=1 for exactly one cycle. Return to IDLE.
//  - busy=1 exactly in cycles T+1..T+11 (11 cycles). Total latency: start to done = 12 cycles.
//  - Next-key function, with w0..w3 the previous round key:
//      t  = SubWord(RotWord(w3)) ^ {rcon,24'h0};  RotWord({a,b,c,d}) = {b,c,d,a}
//      n0 = w0^t;  n1 = w1^n0;  n2 = w2^n1;  n3 = w3^n2
//  - rcon sequence after each generated key: xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
//    Values used for keys 1..10: 01,02,04,08,10,20,40,80,1B,36.
//  - Slots 11..15 are never written.
//  - Between jobs, wr_addr and wr_data hold their last values. wr_en is the only write qualifier.
//  - start while busy or done is asserted: ignored. No queuing.
//  - start held high continuously: a new expansion begins on the first IDLE cycle after FIN.
//    That is one idle gap cycle; next busy rises at T+14.
//  - key_in changing after the start edge has no effect on the job in flight.
//  - rst mid-expansion: immediately forces IDLE and the reset output values, with no further writes.
//    Register-file contents are undefined; the user must restart.
// STRUCTURE
//  - Shared package aes_pkg: KEY_W, ADDR_W, NUM_ROUNDS, the FSM state enum, RCON_INIT=8'h01,
//    and the xtime reduction constant 8'h1B.
//  - Sub-module aes_sbox: combinational 8-bit S-box (256-entry case), instantiated 4x for SubWord.
//  - Top level: FSM, round counter, rcon register, key register, and the next-key XOR chain.
// TESTING
//  1. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c with start pulse:
//     addr0 = the key; addr1 = a0fafe1788542cb123a339392a6c7605; addr10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2. Timing check on the same job: exactly 11 wr_en cycles with addr 0..10 in order; busy 11 cycles;
//     done single pulse 12 cycles after start; no write to slots 11..15.
//  3. All-zero key: addr1 = 62636363626363636263636362636363; addr10 = b4ef5bcb3e92e21123e951cf6f8f188e.
//  4. start pulsed at busy cycle 5 and while done=1: ignored.
//     The write sequence and the addr10 value are identical to test 1.
//  5. rst asserted asynchronously at the addr4 write cycle: outputs go to 0 within the same cycle and no further writes occur.
//     A fresh start after release reproduces test 1 exactly.
//  6. start held high for 30 cycles: two complete back-to-back jobs with one idle cycle between FIN and the second busy.
//     key_in is changed mid-job, and the first job's keys must not be affected.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-expansion constants, FSM state type and xtime helper.
//   KEY_W, ADDR_W, NUM_ROUNDS : round-key width, register-file address width, last round index
//   RCON_INIT, XTIME_POLY     : first round constant and GF(2^8) reduction byte
package aes_pkg;
    localparam int KEY_W      = 128;
    localparam int ADDR_W     = 4;
    localparam int NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1B;
    typedef enum logic [1:0] {IDLE, EXPAND, FIN} state_t;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
//   a : input byte
//   s : substituted byte
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    always_comb begin
        s = 8'h00;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
    end
endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: iterative AES-128 key expansion, one round key written per clock.
//   clk, rst          : clock, asynchronous active-high reset
//   start, key_in     : job request (sampled in IDLE) and cipher key, w0 at the MSBs
//   busy, done        : writing round keys / one-cycle completion pulse
//   wr_en, wr_addr, wr_data : register-file write port, slot = round index
module aes_key_expand_seq
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_in,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [KEY_W-1:0]  wr_data
);
    state_t            state;
    logic [ADDR_W-1:0] round;
    logic [7:0]        rcon;
    logic [KEY_W-1:0]  key;
    logic [KEY_W-1:0]  next_key;
    logic [31:0]       rot;
    logic [31:0]       sub;
    logic [31:0]       t;
    logic [31:0]       n0;
    logic [31:0]       n1;
    logic [31:0]       n2;
    logic [31:0]       n3;

    // RotWord of w3, then SubWord byte by byte
    assign rot = {key[23:0], key[31:24]};
    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (.a(rot[8*g +: 8]), .s(sub[8*g +: 8]));
    end

    assign t        = sub ^ {rcon, 24'h0};
    assign n0       = key[127:96] ^ t;
    assign n1       = key[95:64] ^ n0;
    assign n2       = key[63:32] ^ n1;
    assign n3       = key[31:0] ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            round   <= '0;
            rcon    <= RCON_INIT;
            key     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    key     <= key_in;
                    round   <= '0;
                    rcon    <= RCON_INIT;
                    busy    <= 1'b1;
                    wr_en   <= 1'b1;
                    wr_addr <= '0;
                    wr_data <= key_in;
                    state   <= EXPAND;
                end
                EXPAND: if (round == ADDR_W'(NUM_ROUNDS)) begin
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                    done  <= 1'b1;
                    state <= FIN;
                end else begin
                    key     <= next_key;
                    round   <= round + 1'b1;
                    rcon    <= xtime(rcon);
                    wr_addr <= round + 1'b1;
                    wr_data <= next_key;
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: randomized and directed checks of the key-expansion sequencer against a FIPS-197 model.
module tb_aes_key_expand_seq;
    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         done;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [127:0] wr_data;

    int checks = 0;
    int errors = 0;

    aes_key_expand_seq dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-oriented key schedule: w[i] = w[i-4] ^ f(w[i-1])
    logic [127:0] rk [11];

    task automatic expand_into(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 11; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    // Model: job accepted at edge s when idle; outputs of edge s+k are key k (k<=10), done at k=11,
    // and the sequencer can accept again from edge s+13.
    bit job = 0;
    int e = 0;
    int s = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) job = 0;
        else begin
            e++;
            if (start && (!job || e - s >= 13)) begin
                job = 1;
                s = e;
                expand_into(key_in);
            end
        end
    end

    logic         eb, ed;
    logic [3:0]   ea;
    logic [127:0] ewd;
    int           k;

    always @(negedge clk) begin
        if (job) begin
            k   = e - s;
            eb  = (k <= 10);
            ed  = (k == 11);
            ea  = (k <= 10) ? 4'(k) : 4'd10;
            ewd = (k <= 10) ? rk[k] : rk[10];
        end else begin
            eb = 0; ed = 0; ea = '0; ewd = '0;
        end
        chk("busy", 128'(busy), 128'(eb));
        chk("wr_en", 128'(wr_en), 128'(eb));
        chk("done", 128'(done), 128'(ed));
        chk("wr_addr", 128'(wr_addr), 128'(ea));
        chk("wr_data", wr_data, ewd);
    end

    logic [127:0] mem [16];

    task automatic run_job(input logic [127:0] kk, input int poke, input bit poke_done,
                           output int lat, output int nw, output int nb, output bit ord);
        for (int i = 0; i < 16; i++) mem[i] = '0;
        @(negedge clk);
        key_in = kk;
        start = 1;
        @(negedge clk);
        start = 0;
        lat = 1; nw = 0; nb = 0; ord = 1;
        while (lat < 40) begin
            if (lat == 1) key_in = {$urandom, $urandom, $urandom, $urandom};
            if (wr_en) begin
                if (wr_addr != 4'(nw)) ord = 0;
                mem[wr_addr] = wr_data;
                nw++;
            end
            if (busy) nb++;
            if (done) begin
                start = poke_done;
                break;
            end
            start = (lat == poke);
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) begin
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_40");
        end
        @(negedge clk);
        start = 0;
        @(negedge clk);
    endtask

    int  lat, nw, nb, ndone, d1, b2;
    bit  ord, pb;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        build_sbox();
        expand_into(KEY_A1);
        chk("model_a1_k1", rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_a1_k10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        expand_into('0);
        chk("model_zero_k1", rk[1], 128'h62636363626363636263636362636363);
        chk("model_zero_k10", rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        repeat (3) @(negedge clk);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_data", wr_data, 128'd0);
        #1 rst = 0;

        // FIPS-197 A.1 key, timing of a single job
        run_job(KEY_A1, 0, 0, lat, nw, nb, ord);
        chk("a1_k0", mem[0], KEY_A1);
        chk("a1_k1", mem[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("a1_k10", mem[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("a1_latency", 128'(lat), 128'd12);
        chk("a1_writes", 128'(nw), 128'd11);
        chk("a1_busy_cycles", 128'(nb), 128'd11);
        chk("a1_addr_order", 128'(ord), 128'd1);

        // All-zero key
        run_job('0, 0, 0, lat, nw, nb, ord);
        chk("zero_k1", mem[1], 128'h62636363626363636263636362636363);
        chk("zero_k10", mem[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // start pulses during busy and during done are ignored
        run_job(KEY_A1, 5, 1, lat, nw, nb, ord);
        chk("ign_k10", mem[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("ign_writes", 128'(nw), 128'd11);
        chk("ign_addr_order", 128'(ord), 128'd1);
        repeat (3) @(negedge clk);
        chk("ign_no_restart", 128'(busy), 128'd0);

        // asynchronous reset during the addr4 write cycle
        @(negedge clk);
        key_in = KEY_A1;
        start = 1;
        @(negedge clk);
        start = 0;
        pb = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_en && wr_addr == 4'd4) begin
                pb = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reached_addr4", 128'(pb), 128'd1);
        #2 rst = 1;
        #1;
        chk("rst_async_busy", 128'(busy), 128'd0);
        chk("rst_async_wr_en", 128'(wr_en), 128'd0);
        chk("rst_async_addr", 128'(wr_addr), 128'd0);
        chk("rst_async_data", wr_data, 128'd0);
        repeat (3) @(negedge clk);
        #1 rst = 0;
        repeat (2) @(negedge clk);
        run_job(KEY_A1, 0, 0, lat, nw, nb, ord);
        chk("rst_redo_k1", mem[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("rst_redo_k10", mem[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("rst_redo_latency", 128'(lat), 128'd12);

        // start held high: two back-to-back jobs, key_in changed mid-job
        @(negedge clk);
        key_in = KEY_A1;
        start = 1;
        ndone = 0; d1 = -1; b2 = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 6) key_in = {$urandom, $urandom, $urandom, $urandom};
            if (wr_en && wr_addr == 4'd10 && ndone == 0)
                chk("held_a1_k10", wr_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            if (done) begin
                ndone++;
                if (d1 < 0) d1 = i;
            end
            if (busy && d1 >= 0 && b2 < 0) b2 = i;
        end
        start = 0;
        chk("held_done_count", 128'(ndone), 128'd2);
        chk("held_gap", 128'(b2 - d1), 128'd2);
        repeat (15) @(negedge clk);

        // random keys with random stray starts
        for (int r = 0; r < 15; r++) begin
            run_job({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 14)),
                    1'($urandom_range(0, 1)), lat, nw, nb, ord);
            chk("rnd_latency", 128'(lat), 128'd12);
            chk("rnd_writes", 128'(nw), 128'd11);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
